// File: rtl/led_seq_pkg.sv
`timescale 1ns/1ps
// Types and constants shared by the LED sequence scheduler and its helper blocks.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_PATTERN = 8'h00;
  localparam int         STEP_W       = 4;

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_seq_scheduler_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin selector: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
    for (int off = N - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % N;
      if (req[k]) begin
        onehot    = '0;
        onehot[k] = 1'b1;
        idx       = IW'(k);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_seq_scheduler.sv
`timescale 1ns/1ps
// Shares one 8-bit LED display between NREQ requesters; each winner's seed pattern
// is rotated left once per display step for its requested number of steps.
module led_seq_scheduler
  import led_seq_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8-1:0]        pat_i,
  input  logic [NREQ*STEP_W-1:0]   steps_i,
  input  logic                     abort,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [7:0]               count,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NREQ - 1);

  state_t              state_reg, state_next;
  logic [7:0]          count_reg, count_next;
  logic [NREQ-1:0]     grant_reg, grant_next;
  logic [NREQ-1:0]     done_reg, done_next;
  logic                busy_reg, busy_next;
  logic [IW-1:0]       ptr_reg, ptr_next;
  logic [IW-1:0]       owner_reg, owner_next;
  logic [STEP_W-1:0]   steps_reg, steps_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [TW-1:0]       tick_reg, tick_next;

  logic [7:0]          pat_arr   [NREQ];
  logic [STEP_W-1:0]   steps_arr [NREQ];

  logic [NREQ-1:0]     pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign pat_arr[gi]   = pat_i[gi*8 +: 8];
    assign steps_arr[gi] = steps_i[gi*STEP_W +: STEP_W];
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= IDLE_PATTERN;
      grant_reg <= '0;
      done_reg  <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      steps_reg <= '0;
      step_reg  <= '0;
      tick_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      steps_reg <= steps_next;
      step_reg  <= step_next;
      tick_reg  <= tick_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    grant_next = '0;
    done_next  = '0;
    busy_next  = busy_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    steps_next = steps_reg;
    step_next  = step_reg;
    tick_next  = tick_reg;

    case (state_reg)
      IDLE: begin
        count_next = IDLE_PATTERN;
        if (pick_valid) begin
          state_next = RUN;
          grant_next = pick_onehot;
          count_next = pat_arr[pick_idx];
          steps_next = (steps_arr[pick_idx] == '0) ? STEP_W'(1) : steps_arr[pick_idx];
          owner_next = pick_idx;
          step_next  = '0;
          tick_next  = '0;
          busy_next  = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_next           = DONE;
          done_next[owner_reg] = 1'b1;
          count_next           = IDLE_PATTERN;
        end else if (tick_reg == TICK_LAST) begin
          tick_next = '0;
          // The final terminal tick ends the slot instead of rotating once more.
          if (step_reg == steps_reg - 1'b1) begin
            state_next           = DONE;
            done_next[owner_reg] = 1'b1;
            count_next           = IDLE_PATTERN;
          end else begin
            count_next = rotl1(count_reg);
            step_next  = step_reg + 1'b1;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
        count_next = IDLE_PATTERN;
        busy_next  = 1'b0;
        ptr_next   = (owner_reg == PTR_LAST) ? '0 : owner_reg + 1'b1;
      end

      default: begin
        state_next = IDLE;
        count_next = IDLE_PATTERN;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign count = count_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_led_seq_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for led_seq_scheduler: directed scenarios plus randomized
// slots, each checked cycle by cycle against a slot-level reference model.
module tb_led_seq_scheduler;

  localparam int NREQ = 4;
  localparam int TD   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] pat_i;
  logic [NREQ*4-1:0] steps_i;
  logic              abort;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        count;
  logic              busy;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     ptr_m    = 0;
  longint cyc      = 0;

  led_seq_scheduler #(
    .NREQ     (NREQ),
    .TICK_DIV (TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .pat_i   (pat_i),
    .steps_i (steps_i),
    .abort   (abort),
    .grant   (grant),
    .done    (done),
    .count   (count),
    .busy    (busy)
  );

  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Seed pattern after k left-rotations, computed arithmetically.
  function automatic logic [7:0] rot_by(input logic [7:0] p, input int k);
    int v;
    int s;
    s = k % 8;
    v = int'(p);
    v = (v << s) | (v >> (8 - s));
    return v[7:0];
  endfunction

  function automatic int pick_model(input logic [NREQ-1:0] r);
    for (int off = 0; off < NREQ; off++)
      if (r[(ptr_m + off) % NREQ]) return (ptr_m + off) % NREQ;
    return -1;
  endfunction

  // One full slot from the grant cycle through the trailing IDLE cycle.
  // mode 0: winner drops req on grant; 1: req held; 2: inputs scrambled during RUN.
  task automatic run_slot(input int mode, input int abort_at, output int w,
                          output longint g_cyc, output longint d_cyc,
                          output logic [NREQ-1:0] g_obs);
    logic [7:0]      p;
    logic [7:0]      ec;
    logic [NREQ-1:0] oh, eg, ed;
    logic            eb;
    int              steps_eff;
    int              last;
    w = pick_model(req);
    if (w < 0) w = 0;
    p         = pat_i[w*8 +: 8];
    steps_eff = (steps_i[w*4 +: 4] == 4'd0) ? 1 : int'(steps_i[w*4 +: 4]);
    last      = steps_eff * TD - 1;
    if (abort_at >= 0 && abort_at < last) last = abort_at;
    oh    = '0;
    oh[w] = 1'b1;
    g_cyc = 0;
    d_cyc = 0;
    g_obs = '0;
    for (int c = 0; c <= last + 2; c++) begin
      @(negedge clk);
      eg = '0; ed = '0; ec = 8'h00; eb = 1'b0;
      if (c <= last) begin
        eg = (c == 0) ? oh : '0;
        ec = rot_by(p, c / TD);
        eb = 1'b1;
      end else if (c == last + 1) begin
        ed = oh;
        eb = 1'b1;
      end
      if (c == 0) begin g_cyc = cyc; g_obs = grant; end
      if (c == last + 1) d_cyc = cyc;
      n_checks += 4;
      if (grant !== eg) begin n_fail++; $display("FAIL slot_grant c=%0d got=%b exp=%b", c, grant, eg); end
      if (done !== ed) begin n_fail++; $display("FAIL slot_done c=%0d got=%b exp=%b", c, done, ed); end
      if (count !== ec) begin n_fail++; $display("FAIL slot_count c=%0d got=%h exp=%h", c, count, ec); end
      if (busy !== eb) begin n_fail++; $display("FAIL slot_busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (c == 0 && mode == 0) req[w] = 1'b0;
      if (mode == 2 && c <= last) begin
        req     = NREQ'($urandom);
        pat_i   = $urandom;
        steps_i = 16'($urandom);
      end
      abort = (c == abort_at) && (c <= last);
    end
    ptr_m = (w + 1) % NREQ;
    $display("slot: winner=%0d grant@%0d done@%0d count_seed=%h", w, g_cyc, d_cyc, p);
  endtask

  task automatic test_reset;
    #1.5;
    n_checks += 4;
    if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (grant !== '0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    if (done !== '0) begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
    #0.5 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks += 4;
      if (count !== 8'h00) begin n_fail++; $display("FAIL idle_count i=%0d got=%h exp=00", i, count); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy i=%0d got=%b exp=0", i, busy); end
      if (grant !== '0) begin n_fail++; $display("FAIL idle_grant i=%0d got=%b exp=0000", i, grant); end
      if (done !== '0) begin n_fail++; $display("FAIL idle_done i=%0d got=%b exp=0000", i, done); end
    end
    $display("reset: 20 idle cycles observed");
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g [4];
    logic [NREQ-1:0] go;
    int              w;
    longint          g, d, prev;
    exp_g   = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    req     = 4'b1011;
    pat_i   = {4{8'h80}};
    steps_i = {4{4'd1}};
    prev    = 0;
    for (int i = 0; i < 4; i++) begin
      run_slot(1, -1, w, g, d, go);
      n_checks++;
      if (go !== exp_g[i]) begin n_fail++; $display("FAIL rr_order i=%0d got=%b exp=%b", i, go, exp_g[i]); end
      if (i > 0) begin
        n_checks++;
        if (g - prev != 6) begin n_fail++; $display("FAIL rr_spacing i=%0d got=%0d exp=6", i, g - prev); end
      end
      prev = g;
    end
    req = '0;
  endtask

  task automatic test_single;
    logic [NREQ-1:0] go;
    int              w;
    longint          g, d;
    pat_i        = $urandom;
    pat_i[7:0]   = 8'h01;
    steps_i      = 16'($urandom);
    steps_i[3:0] = 4'd3;
    req          = 4'b0001;
    run_slot(0, -1, w, g, d, go);
    n_checks += 2;
    if (go !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", go); end
    if (d - g != 12) begin n_fail++; $display("FAIL single_length got=%0d exp=12", d - g); end
  endtask

  task automatic test_wrap;
    logic [NREQ-1:0] go;
    int              w;
    longint          g, d;
    pat_i        = $urandom;
    pat_i[7:0]   = 8'h80;
    steps_i      = 16'($urandom);
    steps_i[3:0] = 4'd2;
    req          = 4'b0001;
    run_slot(0, -1, w, g, d, go);
    n_checks++;
    if (d - g != 8) begin n_fail++; $display("FAIL wrap_length got=%0d exp=8", d - g); end
  endtask

  task automatic test_steps_zero;
    logic [NREQ-1:0] go;
    int              w;
    longint          g, d;
    pat_i   = $urandom;
    steps_i = '0;
    req     = NREQ'(1) << $urandom_range(0, NREQ - 1);
    run_slot(0, -1, w, g, d, go);
    n_checks++;
    if (d - g != 4) begin n_fail++; $display("FAIL steps0_length got=%0d exp=4", d - g); end
  endtask

  task automatic test_abort;
    logic [NREQ-1:0] go;
    int              w1, w2;
    longint          g1, d1, g2, d2;
    pat_i   = $urandom;
    steps_i = {4{4'd15}};
    req     = 4'b0110;
    run_slot(1, 1, w1, g1, d1, go);
    n_checks++;
    if (d1 - g1 != 2) begin n_fail++; $display("FAIL abort_done_delay got=%0d exp=2", d1 - g1); end
    steps_i = {4{4'd1}};
    run_slot(1, -1, w2, g2, d2, go);
    n_checks++;
    if (g2 - d1 != 2) begin n_fail++; $display("FAIL abort_next_grant got=%0d exp=2", g2 - d1); end
    req = '0;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] go;
    int              w;
    int              ab;
    longint          g, d;
    for (int i = 0; i < 12; i++) begin
      req   = NREQ'($urandom_range(1, 15));
      pat_i = $urandom;
      for (int k = 0; k < NREQ; k++) steps_i[k*4 +: 4] = 4'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_slot(2, ab, w, g, d, go);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_run;
    logic [NREQ-1:0] go;
    int              w;
    longint          g, d;
    pat_i   = $urandom;
    steps_i = {4{4'd1}};
    req     = 4'b0010;
    run_slot(0, -1, w, g, d, go);
    pat_i[23:16]  = 8'h5A;
    steps_i[11:8] = 4'd10;
    req           = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant got=%b exp=0100", grant); end
    req = '0;
    repeat (3) @(negedge clk);
    #0.5 reset = 1'b0;
    #0.2;
    n_checks += 4;
    if (count !== 8'h00) begin n_fail++; $display("FAIL midrst_count got=%h exp=00", count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (grant !== '0) begin n_fail++; $display("FAIL midrst_grant_clr got=%b exp=0000", grant); end
    if (done !== '0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0000", done); end
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (done !== '0) begin n_fail++; $display("FAIL midrst_no_done i=%0d got=%b exp=0000", i, done); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_busy i=%0d got=%b exp=0", i, busy); end
    end
    req = 4'b1111;
    run_slot(0, -1, w, g, d, go);
    n_checks++;
    if (go !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr got=%b exp=0001", go); end
    req = '0;
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    pat_i   = '0;
    steps_i = '0;
    abort   = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_steps_zero();
    test_abort();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
